// File: rtl/lsu_ctrl_if.sv
// Bundle between the load/store sequencer, the MEM-stage pipeline and data memory.
// slave = the sequencer itself, master = the pipeline/memory environment driving it.
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        done;
   logic [31:0] ld_data;
   logic [2:0]  ext_sel;
   logic        addr_err;
   logic        bus_err;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
             mem_ack, mem_rdata,
      output req_ready, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             done, ld_data, ext_sel, addr_err, bus_err
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
             mem_ack, mem_rdata,
      input  req_ready, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             done, ld_data, ext_sel, addr_err, bus_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, word-aligned memory handshake, lane-shifted load return.
// Optional access timeout is enabled with the LSU_TIMEOUT_EN macro.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | mem_req held, waiting for mem_ack
// DONE   | one-cycle done pulse
// ERR    | one-cycle addr_err or bus_err pulse
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t     state;
   logic [1:0] r_size;
   logic [1:0] r_lane;
   logic       r_unsigned;

   logic        misaligned;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("lsu_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;
   assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      misaligned = 1'b0;
      be_nxt     = 4'b0000;
      wdata_nxt  = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            be_nxt    = 4'b0001 << bus.req_addr[1:0];
            wdata_nxt = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = bus.req_addr[0];
            be_nxt     = 4'b0011 << {bus.req_addr[1], 1'b0};
            wdata_nxt  = {2{bus.req_wdata[15:0]}};
         end
         2'b10: begin
            misaligned = |bus.req_addr[1:0];
            be_nxt     = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         r_size        <= 2'b00;
         r_lane        <= 2'b00;
         r_unsigned    <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_be    <= 4'h0;
         bus.mem_wdata <= 32'h0;
         bus.done      <= 1'b0;
         bus.ld_data   <= 32'h0;
         bus.ext_sel   <= 3'b000;
         bus.addr_err  <= 1'b0;
         bus.bus_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         bus.done     <= 1'b0;
         bus.addr_err <= 1'b0;
         bus.bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_size        <= bus.req_size;
                  r_lane        <= bus.req_addr[1:0];
                  r_unsigned    <= bus.req_unsigned;
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                  to_cnt        <= '0;
`endif
                  if (misaligned) begin
                     state        <= ERR;
                     bus.addr_err <= 1'b1;
                  end else begin
                     state         <= ACCESS;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.req_we;
                     bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                     bus.mem_be    <= be_nxt;
                     bus.mem_wdata <= wdata_nxt;
                  end
               end
            end
            ACCESS: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  bus.done    <= 1'b1;
                  state       <= DONE;
                  // Stores leave the last load result visible to the extend stage.
                  if (!bus.mem_we) begin
                     bus.ld_data <= bus.mem_rdata >> {r_lane, 3'b000};
                     bus.ext_sel <= (r_size == 2'b10) ? 3'b100
                                                      : {1'b0, r_size == 2'b01, r_unsigned};
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (to_hit) begin
                  bus.mem_req <= 1'b0;
                  bus.bus_err <= 1'b1;
                  state       <= ERR;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
`endif
            end
            DONE, ERR: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
               bus.busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases, randomized accesses against a behavioural model.
module tb_lsu_ctrl;
   localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
   localparam int MAX_ACK = TO;
`else
   localparam int MAX_ACK = 8;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [31:0] exp_ld  = 32'h0;
   logic [2:0]  exp_ext = 3'b000;

   lsu_ctrl_if bus ();

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_req(input logic keep_valid);
      bus.req_valid    = keep_valid;
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
   endtask

   // Called one step after a rising edge with the DUT idle; returns likewise.
   task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_cyc, input logic hold);
      logic        mis;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [1:0]  a;
      a    = addr[1:0];
      e_be = 4'b0000;
      e_wd = wdata;
      mis  = 1'b0;
      case (size)
         2'd0: begin e_be[a] = 1'b1; e_wd = {4{wdata[7:0]}}; end
         2'd1: begin mis = a[0]; e_be = a[1] ? 4'b1100 : 4'b0011; e_wd = {2{wdata[15:0]}}; end
         2'd2: begin mis = (a != 2'd0); e_be = 4'b1111; end
         default: mis = 1'b1;
      endcase

      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      tick();
      scramble_req(hold);

      if (mis) begin
         n_vec++;
         if ({bus.req_ready, bus.busy, bus.mem_req, bus.addr_err, bus.done, bus.bus_err,
              bus.ld_data, bus.ext_sel} !== {6'b010100, exp_ld, exp_ext}) begin
            n_err++;
            $display("FAIL addr_err_pulse addr=%h size=%b got rdy/busy/mreq/aerr/done/berr=%b%b%b%b%b%b ld=%h ext=%b want 010100 ld=%h ext=%b",
                     addr, size, bus.req_ready, bus.busy, bus.mem_req, bus.addr_err, bus.done,
                     bus.bus_err, bus.ld_data, bus.ext_sel, exp_ld, exp_ext);
         end
         bus.mem_ack   = 1'($urandom);
         bus.mem_rdata = $urandom;
         tick();
         bus.mem_ack   = 1'b0;
         n_vec++;
         if ({bus.req_ready, bus.busy, bus.mem_req, bus.addr_err, bus.done, bus.bus_err}
             !== 6'b100000) begin
            n_err++;
            $display("FAIL err_to_idle addr=%h got rdy/busy/mreq/aerr/done/berr=%b%b%b%b%b%b want 100000",
                     addr, bus.req_ready, bus.busy, bus.mem_req, bus.addr_err, bus.done, bus.bus_err);
         end
         bus.req_valid = 1'b0;
         return;
      end

      for (int c = 1; c <= ack_cyc; c++) begin
         n_vec++;
         if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.busy,
              bus.req_ready, bus.done, bus.addr_err, bus.bus_err}
             !== {1'b1, we, addr[31:2], 2'b00, e_be, e_wd, 5'b10000}) begin
            n_err++;
            $display("FAIL access_bus cyc=%0d got req=%b we=%b addr=%h be=%b wd=%h busy/rdy/done/aerr/berr=%b%b%b%b%b want req=1 we=%b addr=%h be=%b wd=%h 10000",
                     c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                     bus.busy, bus.req_ready, bus.done, bus.addr_err, bus.bus_err,
                     we, {addr[31:2], 2'b00}, e_be, e_wd);
         end
         bus.mem_ack   = (c == ack_cyc);
         bus.mem_rdata = (c == ack_cyc) ? rdata : $urandom;
         tick();
         bus.mem_ack = 1'b0;
      end

      if (!we) begin
         exp_ld = rdata >> (8 * a);
         case (size)
            2'd2:    exp_ext = 3'b100;
            2'd1:    exp_ext = {2'b01, uns};
            default: exp_ext = {2'b00, uns};
         endcase
      end
      n_vec++;
      if ({bus.mem_req, bus.done, bus.busy, bus.req_ready, bus.addr_err, bus.bus_err,
           bus.ld_data, bus.ext_sel} !== {6'b011000, exp_ld, exp_ext}) begin
         n_err++;
         $display("FAIL done_cycle addr=%h got req/done/busy/rdy/aerr/berr=%b%b%b%b%b%b ld=%h ext=%b want 011000 ld=%h ext=%b",
                  addr, bus.mem_req, bus.done, bus.busy, bus.req_ready, bus.addr_err,
                  bus.bus_err, bus.ld_data, bus.ext_sel, exp_ld, exp_ext);
      end
      tick();
      n_vec++;
      if ({bus.done, bus.busy, bus.req_ready, bus.mem_req} !== 4'b0010) begin
         n_err++;
         $display("FAIL back_to_idle got done/busy/rdy/req=%b%b%b%b want 0010",
                  bus.done, bus.busy, bus.req_ready, bus.mem_req);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      scramble_req(1'b0);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      rst_n = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({bus.req_ready, bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
           bus.mem_wdata, bus.done, bus.ld_data, bus.ext_sel, bus.addr_err, bus.bus_err}
          !== {4'b1000, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 3'b000, 2'b00}) begin
         n_err++;
         $display("FAIL reset_state got rdy=%b busy=%b req=%b we=%b addr=%h be=%b wd=%h done=%b ld=%h ext=%b aerr=%b berr=%b want rdy=1, all else 0",
                  bus.req_ready, bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
                  bus.mem_wdata, bus.done, bus.ld_data, bus.ext_sel, bus.addr_err, bus.bus_err);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      run_access(1'b0, 2'b00, 1'b0, 32'h0000_1003, $urandom, 32'h80FF_1234, 3, 1'b0);
      n_vec++;
      if ({bus.ld_data, bus.ext_sel} !== {32'h0000_0080, 3'b000}) begin
         n_err++;
         $display("FAIL lb_1003 got ld=%h ext=%b want ld=00000080 ext=000", bus.ld_data, bus.ext_sel);
      end
      run_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, $urandom, 2, 1'b0);
      n_vec++;
      if ({bus.ld_data, bus.ext_sel} !== {32'h0000_0080, 3'b000}) begin
         n_err++;
         $display("FAIL sh_keeps_ld got ld=%h ext=%b want ld=00000080 ext=000", bus.ld_data, bus.ext_sel);
      end
      run_access(1'b0, 2'b10, 1'b0, 32'h0000_3001, $urandom, $urandom, 1, 1'b0);
      run_access(1'b0, 2'b01, 1'b1, 32'h0000_3001, $urandom, $urandom, 1, 1'b0);
      run_access(1'b0, 2'b01, 1'b1, 32'h0000_4002, $urandom, 32'hFFEE_0000, 1, 1'b0);
      n_vec++;
      if ({bus.ld_data, bus.ext_sel} !== {32'h0000_FFEE, 3'b011}) begin
         n_err++;
         $display("FAIL lhu_4002 got ld=%h ext=%b want ld=0000ffee ext=011", bus.ld_data, bus.ext_sel);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         run_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(MAX_ACK, 1)), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         run_access(1'($urandom), 2'($urandom_range(2, 0)), 1'($urandom),
                    {$urandom} & 32'hFFFF_FFFC, $urandom, $urandom, 1, 1'b1);
      end
   endtask

   task automatic test_async_reset();
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0000_5000;
      tick();
      bus.req_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_ld  = 32'h0;
      exp_ext = 3'b000;
      n_vec++;
      if ({bus.mem_req, bus.busy, bus.req_ready, bus.done, bus.ld_data, bus.ext_sel,
           bus.mem_addr, bus.mem_be} !== {4'b0010, 32'h0, 3'b000, 32'h0, 4'h0}) begin
         n_err++;
         $display("FAIL async_reset got req/busy/rdy/done=%b%b%b%b ld=%h ext=%b addr=%h be=%b want 0010 and zeros",
                  bus.mem_req, bus.busy, bus.req_ready, bus.done, bus.ld_data, bus.ext_sel,
                  bus.mem_addr, bus.mem_be);
      end
      tick();
      rst_n = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++;
         if ({bus.done, bus.mem_req, bus.req_ready, bus.busy, bus.ld_data}
             !== {4'b0010, 32'h0}) begin
            n_err++;
            $display("FAIL ack_after_reset cyc=%0d got done/req/rdy/busy=%b%b%b%b ld=%h want 0010 ld=0",
                     c, bus.done, bus.mem_req, bus.req_ready, bus.busy, bus.ld_data);
         end
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0000_6000;
      tick();
      bus.req_valid = 1'b0;
      for (int c = 1; c <= TO; c++) begin
         n_vec++;
         if ({bus.mem_req, bus.bus_err, bus.done} !== 3'b100) begin
            n_err++;
            $display("FAIL timeout_wait cyc=%0d got req/berr/done=%b%b%b want 100",
                     c, bus.mem_req, bus.bus_err, bus.done);
         end
         tick();
      end
      n_vec++;
      if ({bus.mem_req, bus.bus_err, bus.addr_err, bus.done, bus.busy, bus.req_ready,
           bus.ld_data} !== {6'b010010, exp_ld}) begin
         n_err++;
         $display("FAIL timeout_pulse got req/berr/aerr/done/busy/rdy=%b%b%b%b%b%b ld=%h want 010010 ld=%h",
                  bus.mem_req, bus.bus_err, bus.addr_err, bus.done, bus.busy, bus.req_ready,
                  bus.ld_data, exp_ld);
      end
      tick();
      n_vec++;
      if ({bus.bus_err, bus.done, bus.req_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL timeout_idle got berr/done/rdy=%b%b%b want 001",
                  bus.bus_err, bus.done, bus.req_ready);
      end
      run_access(1'b0, 2'b10, 1'b1, 32'h0000_7000, $urandom, 32'h1357_9BDF, TO, 1'b0);
`else
      run_access(1'b0, 2'b10, 1'b1, 32'h0000_7000, $urandom, 32'h1357_9BDF, 40, 1'b0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
